// File: rtl/acc_sample_pkg.sv
// Shared types and register-map constants for the acc_sample_ctrl sampler.
package acc_sample_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_BOTH_BIT = 1;
   localparam int CTRL_DIV_LSB  = 8;
   localparam int CTRL_DEB_LSB  = 28;

endpackage

// File: rtl/acc_tick_div.sv
// Sample-tick divider: counts 0..div while enabled and pulses tick on the wrap.
// Latency: tick is combinational from the registered count; div=0 ticks every cycle.
// Backpressure: none; the count is held at 0 while disabled.
module acc_tick_div #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // >= so that lowering div mid-count wraps at once instead of running to 2^DIV_W
   assign tick = enable && (cnt >= div);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!enable || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/acc_sample_ctrl.sv
// Avalon-MM sampler: synchronised in_port, tick-paced whole-byte debounce, edge capture, masked irq (ACC_SAMPLE_CTRL_FALL_EDGE_EN adds falling edges).
// Latency: readdata 1 cycle after address; irq 1 cycle after capture or mask changes.
// Backpressure: none; the slave accepts every access with no wait states.
module acc_sample_ctrl
   import acc_sample_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16,
   parameter int DEB_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [DATA_W-1:0] in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   logic [DATA_W-1:0] sync_meta, sync;
   logic [DATA_W-1:0] stable, capture, mask;
   logic [DATA_W-1:0] cand, cand_nxt;
   logic [DEB_W-1:0]  match, match_nxt;
   logic [DEB_W-1:0]  ctrl_deb;
   logic [DIV_W-1:0]  ctrl_div;
   logic              ctrl_en, ctrl_both;
   logic              tick, commit, wr_en;
   logic [DATA_W-1:0] edge_set, w1c;
   logic [31:0]       ctrl_rd, rd_mux;
   logic              unused_wdata;
   state_t            state, state_nxt;

   assign wr_en        = chipselect && !write_n;
   assign unused_wdata = ^writedata;

   acc_tick_div #(.DIV_W(DIV_W)) u_tick_div (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (ctrl_en),
      .div     (ctrl_div),
      .tick    (tick)
   );

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      match_nxt = match;
      commit    = 1'b0;
      if (!ctrl_en) begin
         state_nxt = IDLE;
         cand_nxt  = '0;
         match_nxt = '0;
      end else begin
         case (state)
            IDLE:  state_nxt = TRACK;
            TRACK: begin
               if (tick && (sync != stable)) begin
                  cand_nxt  = sync;
                  match_nxt = '0;
                  state_nxt = SETTLE;
               end
            end
            SETTLE: begin
               if (tick) begin
                  if (sync != cand) begin
                     cand_nxt  = sync;
                     match_nxt = '0;
                  end else if (match >= ctrl_deb) begin
                     commit    = 1'b1;
                     state_nxt = TRACK;
                  end else if (match != '1) begin
                     match_nxt = match + DEB_W'(1);
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cand  <= '0;
         match <= '0;
      end else begin
         state <= state_nxt;
         cand  <= cand_nxt;
         match <= match_nxt;
      end
   end

   // Rising edges always; both edges only when the optional mode bit is set
   assign edge_set = !commit   ? '0 :
                     ctrl_both ? (cand ^ stable) : (cand & ~stable);
   assign w1c      = (wr_en && address == ADDR_EDGE) ? writedata[DATA_W-1:0] : '0;

`ifdef ACC_SAMPLE_CTRL_FALL_EDGE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_both <= 1'b0;
      end else if (wr_en && address == ADDR_CTRL) begin
         ctrl_both <= writedata[CTRL_BOTH_BIT];
      end
   end
`else
   assign ctrl_both = 1'b0;
`endif

   always_comb begin
      ctrl_rd                            = '0;
      ctrl_rd[CTRL_EN_BIT]               = ctrl_en;
      ctrl_rd[CTRL_BOTH_BIT]             = ctrl_both;
      ctrl_rd[CTRL_DIV_LSB +: DIV_W]     = ctrl_div;
      ctrl_rd[CTRL_DEB_LSB +: DEB_W]     = ctrl_deb;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux = 32'(stable);
         ADDR_CTRL: rd_mux = ctrl_rd;
         ADDR_MASK: rd_mux = 32'(mask);
         ADDR_EDGE: rd_mux = 32'(capture);
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '0;
         sync      <= '0;
         stable    <= '0;
         capture   <= '0;
         mask      <= '0;
         ctrl_en   <= 1'b0;
         ctrl_div  <= '0;
         ctrl_deb  <= '0;
         irq       <= 1'b0;
         readdata  <= '0;
      end else begin
         sync_meta <= in_port;
         sync      <= sync_meta;
         if (commit) begin
            stable <= cand;
         end
         // A set on the commit edge overrides a simultaneous clear
         capture  <= (capture & ~w1c) | edge_set;
         irq      <= |(capture & mask);
         readdata <= rd_mux;
         if (wr_en && address == ADDR_CTRL) begin
            ctrl_en  <= writedata[CTRL_EN_BIT];
            ctrl_div <= writedata[CTRL_DIV_LSB +: DIV_W];
            ctrl_deb <= writedata[CTRL_DEB_LSB +: DEB_W];
         end
         if (wr_en && address == ADDR_MASK) begin
            mask <= writedata[DATA_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_acc_sample_ctrl.sv
// Bench for acc_sample_ctrl: register-map vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a run-length debounce reference model.
module tb_acc_sample_ctrl;

   localparam int DATA_W = 8;
   localparam int DIV_W  = 16;
   localparam int DEB_W  = 4;
`ifdef ACC_SAMPLE_CTRL_FALL_EDGE_EN
   localparam logic [31:0] CTRL_TBL_EXP = 32'h3001_2302;
`else
   localparam logic [31:0] CTRL_TBL_EXP = 32'h3001_2300;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [DATA_W-1:0] in_port;
   logic [31:0]       readdata;
   logic              irq;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [DATA_W-1:0] m_s1, m_s2, m_stable, m_cap, m_mask, run_val;
   logic [DIV_W-1:0]  m_div;
   logic [DEB_W-1:0]  m_deb;
   logic              m_en, m_both;
   int                en_cnt, run_len;
   logic [31:0]       exp_rd;
   logic              exp_irq;

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[$];

   acc_sample_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W), .DEB_W(DEB_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_cap = '0; m_mask = '0; run_val = '0;
      m_div = '0; m_deb = '0; m_en = 1'b0; m_both = 1'b0;
      en_cnt = 0; run_len = 0; exp_rd = '0; exp_irq = 1'b0;
   endtask

   // Debounce as a run-length rule: a value differing from stable commits once deb+2
   // consecutive ticks have sampled it; the first enabled cycle after a disable ignores ticks.
   task automatic model_step();
      logic [DATA_W-1:0] edges, w1c;
      edges = '0;
      w1c   = '0;
      if (!reset_n) begin
         model_clear();
         return;
      end
      exp_irq = |(m_cap & m_mask);
      case (address)
         2'd0:    exp_rd = 32'(m_stable);
         2'd1:    exp_rd = (32'(m_deb) << 28) | (32'(m_div) << 8) | (32'(m_both) << 1) | 32'(m_en);
         2'd2:    exp_rd = 32'(m_mask);
         default: exp_rd = 32'(m_cap);
      endcase
      if (m_en) begin
         if (en_cnt >= 1 && (en_cnt % (int'(m_div) + 1)) == int'(m_div)) begin
            if (run_len == 0) begin
               if (m_s2 != m_stable) begin
                  run_val = m_s2;
                  run_len = 1;
               end
            end else if (m_s2 != run_val) begin
               run_val = m_s2;
               run_len = 1;
            end else begin
               run_len++;
               if (run_len >= int'(m_deb) + 2) begin
                  edges    = m_both ? (run_val ^ m_stable) : (run_val & ~m_stable);
                  m_stable = run_val;
                  run_len  = 0;
               end
            end
         end
         en_cnt++;
      end else begin
         en_cnt  = 0;
         run_len = 0;
      end
      if (chipselect && !write_n) begin
         case (address)
            2'd1: begin
               m_en  = writedata[0];
`ifdef ACC_SAMPLE_CTRL_FALL_EDGE_EN
               m_both = writedata[1];
`endif
               m_div = writedata[23:8];
               m_deb = writedata[31:28];
            end
            2'd2:    m_mask = writedata[DATA_W-1:0];
            2'd3:    w1c = writedata[DATA_W-1:0];
            default: ;
         endcase
      end
      m_cap = (m_cap & ~w1c) | edges;
      m_s2  = m_s1;
      m_s1  = in_port;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("readdata", readdata, exp_rd);
      chk("irq", {31'b0, irq}, {31'b0, exp_irq});
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      cyc();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      cyc();
      d = readdata;
   endtask

   task automatic wait_rd(input logic [1:0] a, input logic [31:0] v, input int max, input string name);
      bit hit;
      hit = 1'b0;
      address = a;
      for (int i = 0; i < max && !hit; i++) begin
         cyc();
         if (readdata == v) hit = 1'b1;
      end
      chk(name, readdata, v);
   endtask

   initial begin
      logic [31:0] v;
      int ones, hold;
      logic [15:0] rdiv;
      logic [3:0]  rdeb;

      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;
      model_clear();
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();

      // glitch shorter than one tick period must not commit
      wr(2'd1, 32'h3000_0301);
      in_port = 8'h00;
      repeat (8) cyc();
      in_port = 8'h01;
      repeat (4) cyc();
      in_port = 8'h00;
      repeat (40) cyc();
      rd(2'd0, v); chk("glitch_stable", v, 32'h0);
      rd(2'd3, v); chk("glitch_capture", v, 32'h0);

      // steady byte commits after deb_len+1 confirming ticks
      wr(2'd2, 32'h02);
      wr(2'd1, 32'h2000_0301);
      in_port = 8'h5A;
      wait_rd(2'd0, 32'h5A, 24, "debounce_accept");
      rd(2'd3, v); chk("capture_5a", v, 32'h5A);
      chk("irq_set", {31'b0, irq}, 32'h1);

      wr(2'd3, 32'h02);
      rd(2'd3, v); chk("w1c_capture", v, 32'h58);
      chk("w1c_irq_clear", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h08);
      cyc();
      chk("mask8_irq", {31'b0, irq}, 32'h1);

      // commit of bit0 under a continuous W1C of bit0: bit0 must be visible exactly once
      wr(2'd1, 32'h0);
      wr(2'd1, 32'h0000_0001);
      in_port = 8'h5B;
      address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
      ones = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (readdata[0]) ones++;
      end
      chipselect = 1'b0; write_n = 1'b1;
      chk("collision_set_wins", 32'(ones), 32'd1);

      // disable mid-SETTLE, then re-enable: commit restarts from match=0
      wr(2'd1, 32'h0);
      wr(2'd1, 32'h3000_0301);
      in_port = 8'h00;
      repeat (8) cyc();
      wr(2'd1, 32'h3000_0300);
      repeat (5) cyc();
      rd(2'd0, v); chk("disable_keeps_stable", v, 32'h5B);
      wr(2'd1, 32'h3000_0301);
      address = 2'd0;
      repeat (17) cyc();
      chk("no_early_commit", readdata, 32'h5B);
      wait_rd(2'd0, 32'h0, 10, "reenable_commit");

      // randomized traffic against the reference model
      hold = 0;
      for (int r = 0; r < 4; r++) begin
         wr(2'd1, 32'h0);
         rdiv = 16'($urandom_range(0, 3));
         rdeb = 4'($urandom_range(0, 3));
         wr(2'd2, 32'($urandom_range(0, 255)));
         wr(2'd1, (32'(rdeb) << 28) | (32'(rdiv) << 8) | 32'h1);
         for (int k = 0; k < 250; k++) begin
            if (hold == 0) begin
               in_port = 8'($urandom_range(0, 255));
               hold = $urandom_range(1, 24);
            end
            hold--;
            if ($urandom_range(0, 9) == 0) begin
               address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
            end else begin
               chipselect = 1'b0; write_n = 1'b1; address = 2'($urandom_range(0, 3));
            end
            cyc();
         end
         chipselect = 1'b0; write_n = 1'b1;
      end

      // asynchronous reset in the middle of traffic
      wr(2'd2, 32'hFF);
      address = 2'd3;
      repeat (5) cyc();
      reset_n = 1'b0;
      #2;
      chk("async_rst_readdata", readdata, 32'h0);
      chk("async_rst_irq", {31'b0, irq}, 32'h0);
      in_port = 8'h00;
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();

      tbl.push_back('{1'b0, 2'd0, 32'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd1, 32'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd3, 32'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd1, 32'h3F01_23FE, 32'h0});
      tbl.push_back('{1'b0, 2'd1, 32'h0, CTRL_TBL_EXP});
      tbl.push_back('{1'b1, 2'd2, 32'hFFFF_FFA5, 32'h0});
      tbl.push_back('{1'b0, 2'd2, 32'h0, 32'h0000_00A5});
      tbl.push_back('{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b0, 2'd0, 32'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd3, 32'h0000_00FF, 32'h0});
      tbl.push_back('{1'b0, 2'd3, 32'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd1, 32'h0000_FF00, 32'h0});
      tbl.push_back('{1'b0, 2'd1, 32'h0, 32'h0000_FF00});
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].we) begin
            wr(tbl[i].addr, tbl[i].wdata);
         end else begin
            rd(tbl[i].addr, v);
            chk($sformatf("tbl%0d", i), v, tbl[i].exp);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
